// File: rtl/paddle_pot_emu.sv
// Paddle potentiometer emulator: per-channel position registers moved once per frame,
// plus a frame-synchronous discharge/charge sequencer that produces pot-comparator pulses.
module paddle_pot_emu #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned POS_MIN      = 0,
  parameter int unsigned POS_MAX      = 255,
  parameter int unsigned STEP         = 2,
  parameter int unsigned ACCEL        = 6,
  parameter int unsigned ACCEL_FRAMES = 8,
  parameter int unsigned DISCH_CYC    = 64,
  parameter int unsigned BASE         = 16,
  parameter int unsigned SHIFT        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      vsync,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       down,
  input  logic [CHANNELS-1:0]       center,
  output logic [CHANNELS*POS_W-1:0] pos,
  output logic [CHANNELS-1:0]       pot_out,
  output logic [CHANNELS-1:0]       pot_dwn,
  output logic                      busy
);

  localparam int unsigned CHG_MAX = BASE + ((POS_MAX - POS_MIN) << SHIFT);
  localparam int unsigned CNT_TOP = (DISCH_CYC > CHG_MAX) ? DISCH_CYC : CHG_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);
  localparam int unsigned HELD_W  = $clog2(ACCEL_FRAMES + 1);
  localparam int unsigned CENTER  = (POS_MIN + POS_MAX) / 2;

  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [POS_W:0]    ext_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [HELD_W-1:0] held_t;
  typedef enum logic [1:0] {IDLE, DISCH, CHARGE, DONE} state_t;

  state_t              state_q, state_n;
  cnt_t                cnt_q, cnt_n;
  logic [CHANNELS-1:0] pot_q, pot_n;
  logic                vsync_q, armed_q, frame_edge;
  pos_t                pos_q [CHANNELS];
  pos_t                pos_n [CHANNELS];
  held_t               held_q [CHANNELS];
  held_t               held_n [CHANNELS];
  logic [CHANNELS-1:0] dir_up_q, dir_up_n;
  ext_t                ext [CHANNELS];
  ext_t                stp [CHANNELS];
  cnt_t                tgt [CHANNELS];

  // armed_q blocks a frame edge after reset until vsync has been observed low
  assign frame_edge = ce & vsync & ~vsync_q & armed_q;

  always_comb begin
    dir_up_n = dir_up_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pos_n[i]  = pos_q[i];
      held_n[i] = held_q[i];
      ext[i]    = {1'b0, pos_q[i]};
      stp[i]    = (held_q[i] >= held_t'(ACCEL_FRAMES)) ? ext_t'(ACCEL) : ext_t'(STEP);
      tgt[i]    = cnt_t'(BASE) + (cnt_t'(pos_q[i] - pos_t'(POS_MIN)) << SHIFT);
      if (center[i]) begin
        pos_n[i]  = pos_t'(CENTER);
        held_n[i] = '0;
      end else if (up[i] == down[i]) begin
        held_n[i] = '0;
      end else begin
        if (up[i])
          pos_n[i] = (ext[i] + stp[i] > ext_t'(POS_MAX)) ? pos_t'(POS_MAX) : pos_t'(ext[i] + stp[i]);
        else
          pos_n[i] = (ext[i] < ext_t'(POS_MIN) + stp[i]) ? pos_t'(POS_MIN) : pos_t'(ext[i] - stp[i]);
        if (held_q[i] != '0 && dir_up_q[i] == up[i])
          held_n[i] = (held_q[i] == held_t'(ACCEL_FRAMES)) ? held_q[i] : held_q[i] + held_t'(1);
        else
          held_n[i] = held_t'(1);
        dir_up_n[i] = up[i];
      end
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    pot_n   = pot_q;
    if (frame_edge) begin
      state_n = DISCH;
      cnt_n   = '0;
      pot_n   = '0;
    end else if (ce) begin
      case (state_q)
        DISCH: begin
          if (cnt_q == cnt_t'(DISCH_CYC - 1)) begin
            state_n = CHARGE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + cnt_t'(1);
          end
        end
        CHARGE: begin
          for (int unsigned i = 0; i < CHANNELS; i++)
            if (cnt_q == tgt[i]) pot_n[i] = 1'b1;
          if (cnt_q == cnt_t'(CHG_MAX)) begin
            state_n = DONE;
            pot_n   = '1;
          end else begin
            cnt_n = cnt_q + cnt_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pot_q    <= '0;
      vsync_q  <= 1'b0;
      armed_q  <= 1'b0;
      dir_up_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pos_q[i]  <= pos_t'(CENTER);
        held_q[i] <= '0;
      end
    end else if (ce) begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pot_q   <= pot_n;
      vsync_q <= vsync;
      armed_q <= armed_q | ~vsync;
      if (frame_edge) begin
        dir_up_q <= dir_up_n;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          pos_q[i]  <= pos_n[i];
          held_q[i] <= held_n[i];
        end
      end
    end
  end

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      pos[i*POS_W +: POS_W] = pos_q[i];
  end

  assign pot_out = pot_q;
  assign pot_dwn = {CHANNELS{state_q == DISCH}};
  assign busy    = (state_q == DISCH) || (state_q == CHARGE);

endmodule

// File: tb/tb_paddle_pot_emu.sv
// Randomized bench for paddle_pot_emu: a frame-level model predicts positions from the
// movement rules and pot outputs from the number of ce cycles elapsed since the last frame edge.
module tb_paddle_pot_emu;

  localparam int CH       = 2;
  localparam int CENTER   = 127;
  localparam int DISCH    = 64;
  localparam int BASE     = 16;
  localparam int LAST     = BASE + 255 * 4;
  localparam int DONE_K   = DISCH + 1 + LAST;

  logic          clk = 1'b0;
  logic          reset, ce, vsync;
  logic [CH-1:0] up, down, center;
  logic [15:0]   pos;
  logic [CH-1:0] pot_out, pot_dwn;
  logic          busy;

  int nvec = 0;
  int nerr = 0;

  int mpos [CH];
  int mheld [CH];
  bit mdir [CH];
  bit mvq, marmed, mstart;
  int mk;

  always #5 clk = ~clk;

  paddle_pot_emu #(
    .CHANNELS(2), .POS_W(8), .POS_MIN(0), .POS_MAX(255), .STEP(2), .ACCEL(6),
    .ACCEL_FRAMES(8), .DISCH_CYC(64), .BASE(16), .SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .vsync(vsync), .up(up), .down(down),
    .center(center), .pos(pos), .pot_out(pot_out), .pot_dwn(pot_dwn), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mpos[i]  = CENTER;
      mheld[i] = 0;
      mdir[i]  = 1'b0;
    end
    mvq = 1'b0; marmed = 1'b0; mstart = 1'b0; mk = 0;
  endtask

  task automatic model_clock();
    bit e;
    int s;
    if (reset || !ce) return;
    e = vsync && !mvq && marmed;
    if (!vsync) marmed = 1'b1;
    mvq = vsync;
    if (e) begin
      for (int i = 0; i < CH; i++) begin
        if (center[i]) begin
          mpos[i] = CENTER; mheld[i] = 0;
        end else if (up[i] == down[i]) begin
          mheld[i] = 0;
        end else begin
          s = (mheld[i] >= 8) ? 6 : 2;
          if (up[i]) mpos[i] = (mpos[i] + s > 255) ? 255 : mpos[i] + s;
          else       mpos[i] = (mpos[i] - s < 0) ? 0 : mpos[i] - s;
          if (mheld[i] > 0 && mdir[i] == up[i]) mheld[i] = (mheld[i] >= 8) ? 8 : mheld[i] + 1;
          else mheld[i] = 1;
          mdir[i] = up[i];
        end
      end
      mk = 0;
      mstart = 1'b1;
    end else if (mstart && mk < 1000000) begin
      mk++;
    end
  endtask

  task automatic compare_all();
    logic [15:0]   ep;
    logic [CH-1:0] eo;
    for (int i = 0; i < CH; i++) begin
      ep[i*8 +: 8] = 8'(mpos[i]);
      eo[i] = mstart && (mk >= DISCH + 1 + BASE + 4 * mpos[i]);
    end
    check("pos", pos, ep);
    check("pot_out", pot_out, eo);
    check("pot_dwn", pot_dwn, (mstart && mk < DISCH) ? 2'b11 : 2'b00);
    check("busy", busy, mstart && mk < DONE_K);
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      step();
    end
    ce = 1'b1;
  endtask

  task automatic frame();
    ce = 1'b1; vsync = 1'b0; step();
    vsync = 1'b1; step();
    vsync = 1'b0;
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all();
    check("rst_pot_out", pot_out, 2'b00);
    check("rst_pos", pos, 16'h7F7F);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; vsync = 1'b0; up = '0; down = '0; center = '0;
    model_reset();
    #12;
    compare_all();
    check("reset_pos", pos, 16'h7F7F);
    reset = 1'b0;

    // full frame, no input
    frame();
    run(1600);
    check("full_frame_done", pot_out, 2'b11);

    // acceleration on channel 0
    up = 2'b01;
    for (int f = 1; f <= 9; f++) begin
      frame(); run(3);
      if (f == 8) check("accel_f8", pos[7:0], 143);
      if (f == 9) check("accel_f9", pos[7:0], 149);
    end
    up = 2'b00; frame(); run(3);
    up = 2'b01; frame(); run(3);
    check("accel_release", pos[7:0], 151);

    // saturation: ch0 to 0 then climb to 254, ch1 down to 0
    up = 2'b00; down = 2'b11;
    for (int f = 0; f < 40; f++) begin frame(); run(2); end
    check("sat_low0", pos[7:0], 0);
    check("sat_low1", pos[15:8], 0);
    down = 2'b00;
    for (int f = 0; f < 200 && mpos[0] != 254; f++) begin
      up = (mpos[0] >= 248 && mheld[0] != 0) ? 2'b00 : 2'b01;
      frame(); run(2);
    end
    check("reach_254", pos[7:0], 254);
    up = 2'b01; frame(); run(2);
    check("sat_high_a", pos[7:0], 255);
    frame(); run(2);
    check("sat_high_b", pos[7:0], 255);
    up = 2'b11; down = 2'b11; frame(); run(2);
    check("both_hold", pos, 16'h00FF);

    // centre priority over down, then abort mid-charge
    up = 2'b00; down = 2'b10; center = 2'b10; frame(); run(2);
    check("center_prio", pos[15:8], 127);
    center = 2'b00; down = 2'b00;
    for (int i = 0; i < 3000 && mk < DISCH + 1 + 300; i++) begin
      ce = ($urandom_range(0, 3) != 0); step();
    end
    frame();
    check("abort_pot_out", pot_out, 2'b00);
    check("abort_pot_dwn", pot_dwn, 2'b11);

    // ce stall during discharge, then async reset mid-charge with vsync held high
    frame(); run(10);
    ce = 1'b0;
    for (int i = 0; i < 50; i++) step();
    run(1200);
    frame();
    for (int i = 0; i < 3000 && mk < 600; i++) begin
      ce = ($urandom_range(0, 3) != 0); step();
    end
    vsync = 1'b1;
    async_reset();
    ce = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("no_edge_after_reset", busy, 1'b0);
    vsync = 1'b0;
    run(5);

    // random frames
    for (int f = 0; f < 25; f++) begin
      up     = CH'($urandom_range(0, 3));
      down   = CH'($urandom_range(0, 3));
      center = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      frame();
      run($urandom_range(5, 1400));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
